// File: rtl/rom_dl_pkg.sv
// rom_dl_pkg: shared state/region types and the byte counter width for the ROM download sequencer.
package rom_dl_pkg;

    localparam int BC_W = 17;

    typedef enum logic [2:0] {WAIT, LOAD, CHECK, HOLD, RUN} dl_state_t;
    typedef enum logic [1:0] {CPU, GFX, PROM, NONE} region_t;

endpackage

// File: rtl/rom_region_decode.sv
// rom_region_decode: maps a flat download address to its ROM region and the offset within it.
module rom_region_decode
    import rom_dl_pkg::*;
(
    input  logic [15:0]     addr,
    input  logic [BC_W-1:0] cpu_size,
    input  logic [BC_W-1:0] gfx_size,
    input  logic [BC_W-1:0] prom_size,
    output region_t         region,
    output logic [13:0]     offset
);

    logic [BC_W-1:0] a;
    logic [BC_W-1:0] prom_base;
    logic [BC_W-1:0] total;
    logic [BC_W-1:0] base;

    assign a         = BC_W'(addr);
    assign prom_base = cpu_size + gfx_size;
    assign total     = prom_base + prom_size;
    assign region    = a < cpu_size ? CPU : a < prom_base ? GFX : a < total ? PROM : NONE;
    assign base      = region == GFX ? cpu_size : region == PROM ? prom_base : '0;
    assign offset    = 14'(a - base);

endmodule

// File: rtl/rom_dl_ctrl.sv
// rom_dl_ctrl: ioctl ROM download sequencer with region decode, image validation and core reset hold-off.
// Define ROM_DL_CHECKSUM_EN to also require an additive image checksum equal to EXP_SUM.
module rom_dl_ctrl
    import rom_dl_pkg::*;
#(
    parameter int         CPU_SIZE    = 16384,
    parameter int         GFX_SIZE    = 8192,
    parameter int         PROM_SIZE   = 1024,
    parameter int         HOLD_CYCLES = 64,
    parameter logic [7:0] EXP_SUM     = 8'h00
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            dl_active,
    input  logic            dl_wr,
    input  logic [15:0]     dl_addr,
    input  logic [7:0]      dl_data,
    output logic            cpu_we,
    output logic            gfx_we,
    output logic            prom_we,
    output logic [13:0]     wr_addr,
    output logic [7:0]      wr_data,
    output logic            core_reset,
    output logic            dl_done,
    output logic            dl_error,
    output logic [BC_W-1:0] byte_count
);

    localparam logic [BC_W-1:0] TOTAL = BC_W'(CPU_SIZE + GFX_SIZE + PROM_SIZE);

    dl_state_t       state, state_nxt;
    region_t         region;
    logic [13:0]     offset;
    logic            act_q;
    logic            rise, fall, accept, sum_ok;
    logic            ovf, ovf_nxt;
    logic [7:0]      hold_cnt, hold_nxt;
    logic [BC_W-1:0] count_nxt;
    logic [13:0]     waddr_nxt;
    logic [7:0]      wdata_nxt;
    logic            cpu_nxt, gfx_nxt, prom_nxt, crst_nxt, done_nxt, err_nxt;

    rom_region_decode u_decode (
        .addr      (dl_addr),
        .cpu_size  (BC_W'(CPU_SIZE)),
        .gfx_size  (BC_W'(GFX_SIZE)),
        .prom_size (BC_W'(PROM_SIZE)),
        .region    (region),
        .offset    (offset)
    );

    assign rise   = dl_active & ~act_q;
    assign fall   = ~dl_active & act_q;
    assign accept = state == LOAD && dl_wr;

`ifdef ROM_DL_CHECKSUM_EN
    logic [7:0] sum;
    logic       start;
    assign start  = rise && (state == WAIT || state == RUN);
    assign sum_ok = sum == EXP_SUM;
    always_ff @(posedge CLK or posedge RESET)
        if (RESET)
            sum <= '0;
        else if (start)
            sum <= '0;
        else if (accept)
            sum <= sum + dl_data;
`else
    logic unused_exp;
    assign unused_exp = ^EXP_SUM;
    assign sum_ok     = 1'b1;
`endif

    always_comb begin
        state_nxt = state;
        ovf_nxt   = ovf;
        hold_nxt  = hold_cnt;
        count_nxt = byte_count;
        waddr_nxt = wr_addr;
        wdata_nxt = wr_data;
        cpu_nxt   = 1'b0;
        gfx_nxt   = 1'b0;
        prom_nxt  = 1'b0;
        crst_nxt  = core_reset;
        done_nxt  = dl_done;
        err_nxt   = dl_error;
        case (state)
            WAIT, RUN: if (rise) begin
                state_nxt = LOAD;
                ovf_nxt   = 1'b0;
                count_nxt = '0;
                crst_nxt  = 1'b1;
                done_nxt  = 1'b0;
                err_nxt   = 1'b0;
            end
            LOAD: begin
                // a write arriving alongside the dl_active fall still belongs to this image
                if (accept) begin
                    cpu_nxt   = region == CPU;
                    gfx_nxt   = region == GFX;
                    prom_nxt  = region == PROM;
                    waddr_nxt = offset;
                    wdata_nxt = dl_data;
                    ovf_nxt   = ovf | (region == NONE);
                    count_nxt = &byte_count ? byte_count : byte_count + 1'b1;
                end
                if (fall)
                    state_nxt = CHECK;
            end
            CHECK: if (byte_count == TOTAL && !ovf && sum_ok) begin
                state_nxt = HOLD;
                hold_nxt  = 8'(HOLD_CYCLES);
            end else begin
                state_nxt = WAIT;
                err_nxt   = 1'b1;
            end
            HOLD: begin
                hold_nxt = hold_cnt - 8'd1;
                if (hold_cnt == 8'd1) begin
                    state_nxt = RUN;
                    crst_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = WAIT;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET)
        if (RESET) begin
            state      <= WAIT;
            act_q      <= 1'b0;
            ovf        <= 1'b0;
            hold_cnt   <= '0;
            byte_count <= '0;
            wr_addr    <= '0;
            wr_data    <= '0;
            cpu_we     <= 1'b0;
            gfx_we     <= 1'b0;
            prom_we    <= 1'b0;
            core_reset <= 1'b1;
            dl_done    <= 1'b0;
            dl_error   <= 1'b0;
        end else begin
            state      <= state_nxt;
            act_q      <= dl_active;
            ovf        <= ovf_nxt;
            hold_cnt   <= hold_nxt;
            byte_count <= count_nxt;
            wr_addr    <= waddr_nxt;
            wr_data    <= wdata_nxt;
            cpu_we     <= cpu_nxt;
            gfx_we     <= gfx_nxt;
            prom_we    <= prom_nxt;
            core_reset <= crst_nxt;
            dl_done    <= done_nxt;
            dl_error   <= err_nxt;
        end

endmodule
